img_out_streamer: RTL
=====================

IMG_OUT_STREAMER -- requirements
Module: img_out_streamer

Interface
REQ-001 SHALL have parameter AW, default 12, output-memory address width.
REQ-002 SHALL have port clk_50  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse, begins readout (driven from the bilinear core's done).
REQ-005 SHALL have ports i_out_w, i_out_h  input  16 each  output image width/height in pixels.
REQ-006 SHALL have ports busy, done  output  1 each  readout in progress / one-cycle completion pulse.
REQ-007 SHALL have port mem_raddr  output  AW  output-memory read address.
REQ-008 SHALL have port mem_rdata  input  8  output-memory read data, valid exactly 1 cycle after mem_raddr is presented.
REQ-009 SHALL have ports m_valid output 1, m_ready input 1, m_data output 8, m_last output 1  pixel stream to the host side.

Function
REQ-010 SHALL use states IDLE, RUN, FLUSH: IDLE->RUN on start; RUN->FLUSH after the last read is issued; FLUSH->IDLE on the final stream handshake.
REQ-011 SHALL latch total = i_out_w*i_out_h (32-bit product) on start and clamp it to 2^AW.
REQ-012 SHALL go IDLE->IDLE with done pulsed the next cycle and no beats when total is 0.
REQ-013 SHALL issue reads at addresses 0..total-1 in ascending order, exactly one per address, with mem_raddr held at 0 when idle.
REQ-014 SHALL issue a read only when buffered beats plus in-flight reads are fewer than 2, so no beat is ever dropped.
REQ-015 SHALL buffer beats in a 2-entry FIFO whose head drives m_data/m_valid.
REQ-016 SHALL sustain one beat per cycle while m_ready is high, with the first m_valid asserted 2 cycles after start.
REQ-017 SHALL keep m_valid, m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-018 SHALL assert m_last only with the beat for address total-1.
REQ-019 SHALL hold busy high from the cycle after start until the cycle done pulses.
REQ-020 SHALL pulse done for one cycle, one cycle after the m_last handshake.
REQ-021 SHALL ignore start while busy, leaving the latched dimensions unchanged.
REQ-022 SHALL behave normally when simultaneous FIFO push and pop occur at count 1 or 2, leaving the count unchanged.

Reset
REQ-023 SHALL on rst set the state to IDLE and clear busy, done, m_valid, m_last, m_data, mem_raddr, the FIFO and the counters to 0.
REQ-024 SHALL abandon any transfer when rst is asserted mid-operation, discard any in-flight read, and produce no further beats.

Configuration
REQ-025 SHALL, when macro STREAM_CHECKSUM_EN is defined, add output o_checksum (16 bits), the modulo-2^16 sum of all handshaken m_data, cleared on start and on rst, and final in the cycle done pulses.
REQ-026 SHALL, without STREAM_CHECKSUM_EN, omit o_checksum and the adder entirely.

Structure
REQ-027 SHALL take DIM_W=16, PIX_W=8, pixel_t and the state enum from shared package dsa_pkg.
REQ-028 SHALL place the 2-entry FIFO in sub-module stream_fifo2 (push, pop, data, count, full, empty).

Verification
REQ-029 SHALL cover w=4, h=4 with memory holding addr&0xFF and m_ready=1: 16 consecutive beats 0..15, m_last on beat 15, done the next cycle.
REQ-030 SHALL cover the same image with m_ready toggling at random at 50%: identical data order, no loss or duplication, and data held stable during stalls.
REQ-031 SHALL cover w=0, h=7: no m_valid, and done exactly 2 cycles after start.
REQ-032 SHALL cover w=51, h=51, AW=12: 2601 beats, with the last at address 2600.
REQ-033 SHALL cover a second start pulse at beat 5 of a 16-beat run: it is ignored, exactly 16 beats are produced, and one done pulse occurs.
REQ-034 SHALL cover rst asserted at beat 8 then a fresh start with w=h=2: no stale beats, and beats 0..3 are produced. With STREAM_CHECKSUM_EN, the 4x4 ramp gives o_checksum=120.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared definitions for the output-image streaming path: pixel and
// dimension widths, the readout state encoding and the total-beat clamp.
package dsa_pkg;

    localparam int DIM_W = 16;
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Limit a pixel count to the number of words the output memory holds.
    function automatic logic [32:0] clamp_total(input logic [31:0] prod, input int unsigned aw);
        logic [32:0] lim;
        lim = 33'd1 << aw;
        return ({1'b0, prod} > lim) ? lim : {1'b0, prod};
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO whose head entry is always visible on data.
// The caller must not push while full unless it pops in the same cycle.
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_50,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         pop_ok;
    logic [1:0]   wr_en;

    assign pop_ok = pop && (count_reg != 2'd0);

    // One write enable per entry, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Storage, pointers and occupancy; push and pop may coincide at any count.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_en[0]) mem_reg[0] <= wdata;
            if (wr_en[1]) mem_reg[1] <= wdata;
            if (push)   wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign data  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/img_out_streamer.sv
// Reads a finished output image from memory (one-cycle read latency) and
// streams it as a valid/ready pixel stream with m_last on the final pixel.
// Optional feature macro: STREAM_CHECKSUM_EN adds o_checksum, the 16-bit
// wrapping sum of every handshaken pixel of the current image.
module img_out_streamer
    import dsa_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] i_out_w,
    input  logic [DIM_W-1:0] i_out_h,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_raddr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last
`ifdef STREAM_CHECKSUM_EN
    ,
    output logic [15:0]      o_checksum
`endif
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_t      state_reg;
    logic [AW:0] total_reg;
    logic [AW:0] issue_cnt_reg;      // reads issued so far, also the address on mem_raddr
    logic        inflight_reg;       // a read was issued last cycle, data is on mem_rdata now
    logic        inflight_last_reg;  // that read was for the final address
    logic        busy_reg;
    logic        done_reg;
    logic        zero_pend_reg;      // empty image accepted, done goes out next cycle

    logic [31:0]  prod_w;
    logic [AW:0]  total_w;
    logic         start_ok;
    logic         pop_w;
    logic         push_w;
    logic         room_w;
    logic         issue_w;
    logic [PIX_W:0] fifo_head;
    logic [1:0]   fifo_count;
    logic         fifo_full;
    logic         fifo_empty;

    assign prod_w   = 32'(i_out_w) * 32'(i_out_h);
    assign total_w  = (AW+1)'(clamp_total(prod_w, AW));
    assign start_ok = start && (state_reg == IDLE) && !busy_reg;

    assign pop_w  = m_valid && m_ready;
    assign push_w = inflight_reg && (!fifo_full || pop_w);

    // Buffered plus in-flight beats, after this cycle's pop, must stay below two.
    assign room_w  = ((fifo_count + {1'b0, inflight_reg}) != 2'd2) || pop_w;
    assign issue_w = (state_reg == RUN) && (issue_cnt_reg != total_reg) && room_w;

    stream_fifo2 #(
        .W(PIX_W + 1)
    ) u_fifo (
        .clk_50 (clk_50),
        .rst    (rst),
        .push   (push_w),
        .pop    (pop_w),
        .wdata  ({inflight_last_reg, pixel_t'(mem_rdata)}),
        .data   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Readout control: address 0 is already on mem_raddr while idle, so the
    // first read is issued in the start cycle itself.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_reg         <= IDLE;
            total_reg         <= '0;
            issue_cnt_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            zero_pend_reg     <= 1'b0;
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (zero_pend_reg) begin
                        zero_pend_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else if (start_ok) begin
                        total_reg <= total_w;
                        busy_reg  <= 1'b1;
                        if (total_w == '0) begin
                            zero_pend_reg <= 1'b1;
                        end else begin
                            state_reg         <= RUN;
                            issue_cnt_reg     <= CNT_ONE;
                            inflight_reg      <= 1'b1;
                            inflight_last_reg <= (total_w == CNT_ONE);
                        end
                    end
                end
                RUN: begin
                    if (issue_w) begin
                        issue_cnt_reg     <= issue_cnt_reg + CNT_ONE;
                        inflight_reg      <= 1'b1;
                        inflight_last_reg <= (issue_cnt_reg == total_reg - CNT_ONE);
                        if (issue_cnt_reg + CNT_ONE == total_reg) state_reg <= FLUSH;
                    end else if (issue_cnt_reg == total_reg) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop_w && m_last) begin
                        state_reg     <= IDLE;
                        issue_cnt_reg <= '0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_raddr = issue_cnt_reg[AW-1:0];
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[PIX_W-1:0];
    assign m_last    = fifo_head[PIX_W] && !fifo_empty;

`ifdef STREAM_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Running sum of accepted pixels, restarted with each accepted start.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (start_ok) begin
            checksum_reg <= '0;
        end else if (pop_w) begin
            checksum_reg <= checksum_reg + {8'd0, m_data};
        end
    end

    assign o_checksum = checksum_reg;
`endif

endmodule
